// File: rtl/i_cache_ctrl_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// slave = cache controller, master = fetch stage plus instruction memory.
//
// Handshakes:
// - Fetch side: READ_DATA is valid only on cycles where BUSYWAIT is low.
//   ADDRESS must stay stable while BUSYWAIT is high.
// - Memory side: MEM_READ high with a stable MEM_ADDRESS is a block request.
//   The block on MEM_READ_DATA is taken on the first cycle of the request
//   that has MEM_BUSYWAIT low.
interface i_cache_ctrl_if #(
   parameter int MEM_ADDR_W = 28
);
   logic [31:0]           ADDRESS;
   logic [31:0]           READ_DATA;
   logic                  BUSYWAIT;
   logic                  MEM_READ;
   logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
   logic [127:0]          MEM_READ_DATA;
   logic                  MEM_BUSYWAIT;
   logic [1:0]            dbg_state;

   modport slave (
      input  ADDRESS, MEM_READ_DATA, MEM_BUSYWAIT,
      output READ_DATA, BUSYWAIT, MEM_READ, MEM_ADDRESS, dbg_state
   );

   modport master (
      output ADDRESS, MEM_READ_DATA, MEM_BUSYWAIT,
      input  READ_DATA, BUSYWAIT, MEM_READ, MEM_ADDRESS, dbg_state
   );
endinterface

// File: rtl/i_cache_ctrl.sv
// Direct-mapped read-only instruction cache controller: zero-latency hits and a block refill on a miss.
// Define I_CACHE_PERF_EN to add the HIT_COUNT / MISS_COUNT performance counters.
module i_cache_ctrl #(
   parameter int INDEX_BITS = 3,
   parameter int MEM_ADDR_W = 28
) (
   input  logic        CLK,
   input  logic        RESET,
   i_cache_ctrl_if.slave bus
`ifdef I_CACHE_PERF_EN
   ,
   output logic [31:0] HIT_COUNT,
   output logic [31:0] MISS_COUNT
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 32 - 4 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_RD = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t                  state_q;
   logic [LINES-1:0]        valid_q;
   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [127:0]            data_q [LINES];
   logic [INDEX_BITS-1:0]   fill_idx_q;
   logic [TAG_W-1:0]        fill_tag_q;
   logic [MEM_ADDR_W-1:0]   blk_addr_q;
   logic [127:0]            fill_data_q;
   logic                    mem_read_q;

   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_W-1:0]        tag;
   logic [1:0]              offset;
   logic                    hit;
   logic                    addr_unused;

`ifdef I_CACHE_PERF_EN
   logic [31:0]             hit_cnt_q;
   logic [31:0]             miss_cnt_q;
   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;
`endif

   assign idx         = bus.ADDRESS[4 +: INDEX_BITS];
   assign tag         = bus.ADDRESS[31 -: TAG_W];
   assign offset      = bus.ADDRESS[3:2];
   assign addr_unused = ^bus.ADDRESS[1:0];
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);

   // Hits are served straight from the array in the same cycle; outside IDLE the word is don't-care.
   assign bus.BUSYWAIT    = (state_q == IDLE) ? ~hit : 1'b1;
   assign bus.READ_DATA   = data_q[idx][32*offset +: 32];
   assign bus.MEM_READ    = mem_read_q;
   assign bus.MEM_ADDRESS = blk_addr_q;
   assign bus.dbg_state   = state_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         mem_read_q  <= 1'b0;
         fill_idx_q  <= '0;
         fill_tag_q  <= '0;
         blk_addr_q  <= '0;
         fill_data_q <= '0;
`ifdef I_CACHE_PERF_EN
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
`ifdef I_CACHE_PERF_EN
                  hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
               end else begin
                  // Latch the line target so a wandering ADDRESS cannot redirect the fill.
                  state_q    <= MEM_RD;
                  mem_read_q <= 1'b1;
                  fill_idx_q <= idx;
                  fill_tag_q <= tag;
                  blk_addr_q <= bus.ADDRESS[31 -: MEM_ADDR_W];
`ifdef I_CACHE_PERF_EN
                  miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
               end
            end
            MEM_RD: begin
               if (!bus.MEM_BUSYWAIT) begin
                  fill_data_q <= bus.MEM_READ_DATA;
                  mem_read_q  <= 1'b0;
                  state_q     <= UPDATE;
               end
            end
            UPDATE: begin
               valid_q[fill_idx_q] <= 1'b1;
               state_q             <= IDLE;
            end
            default: begin
               state_q    <= IDLE;
               mem_read_q <= 1'b0;
            end
         endcase
      end
   end

   // Data and tag storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge CLK) begin
      if (state_q == UPDATE) begin
         data_q[fill_idx_q] <= fill_data_q;
         tag_q[fill_idx_q]  <= fill_tag_q;
      end
   end

endmodule

// File: doc/i_cache_ctrl.md
Name: i_cache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and instruction memory.
- Fetch side: a 32-bit byte PC goes in; a 32-bit instruction comes out with a BUSYWAIT stall flag.
- Memory side: on a miss, fetches one 128-bit block (4 words) from instruction memory through a busywait handshake, fills the line, then serves the hit.

Parameters:
- INDEX_BITS, 3, log2 of the number of lines (default 8 lines).
- MEM_ADDR_W, 28, block-address width to memory (32 − 4 offset bits).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ADDRESS  in  32  fetch byte address (PC). Bits [1:0] are ignored.
- READ_DATA  out  32  instruction word.
- BUSYWAIT  out  1  fetch stall. High means READ_DATA is not valid.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  MEM_ADDR_W  block address, equal to ADDRESS[31:4].
- MEM_READ_DATA  in  128  returned block. Word0 is in [31:0].
- MEM_BUSYWAIT  in  1  memory busy. The block is valid on the cycle MEM_BUSYWAIT is low after a request.

Behaviour:
- Address split: offset = ADDRESS[3:2], index = ADDRESS[4+INDEX_BITS-1:4], tag = the remaining upper bits.
- Storage per line: valid bit, tag, 128-bit data.
- Hit = valid[index] AND (tag[index] == tag). Evaluated combinationally in IDLE.
- On a hit, READ_DATA is the selected word in the same cycle (0 latency) and BUSYWAIT = 0.
- States:
  - IDLE: hit → stay, BUSYWAIT = 0. Miss → BUSYWAIT = 1 combinationally in the same cycle; next state MEM_READ.
  - MEM_READ: MEM_READ = 1; MEM_ADDRESS = ADDRESS[31:4], held stable. While MEM_BUSYWAIT = 1, stay. When MEM_BUSYWAIT = 0, capture MEM_READ_DATA and go to UPDATE. BUSYWAIT = 1.
  - UPDATE: write data, tag and valid = 1 into the line at index; MEM_READ = 0; BUSYWAIT = 1; next state IDLE. The hit is then served the following cycle.
- Miss penalty: 2 + N cycles, where N is the number of cycles MEM_BUSYWAIT stays high.
- ADDRESS is held stable by the fetch stage while BUSYWAIT = 1. The block uses the values latched at MEM_READ entry (index, tag, block address), so a changing ADDRESS mid-miss cannot corrupt the fill.
- A conflict miss replaces the line unconditionally. There is no write-back (read-only cache).
- READ_DATA during a miss holds the last-selected word of the indexed line. It is don't-care when BUSYWAIT = 1.
- Reset (asynchronous, any state, including mid-miss):
  - state → IDLE; all valid bits → 0; MEM_READ = 0.
  - A refill in flight is abandoned with no line written.
  - Data and tag arrays are not required to reset.
- The first fetch after reset always misses.

Optional Feature:
- Macro: I_CACHE_PERF_EN.
- With the macro defined:
  - Adds outputs HIT_COUNT (32, out) and MISS_COUNT (32, out), both reset to 0.
  - HIT_COUNT increments once per cycle in IDLE with hit = 1.
  - MISS_COUNT increments once per IDLE→MEM_READ transition.
  - Both counters wrap at 2^32.
- Without the macro: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Cold miss: reset, ADDRESS = 0x00000000, MEM_BUSYWAIT high 3 cycles, block = {0x44,0x33,0x22,0x11}.
  - BUSYWAIT = 1 same cycle.
  - MEM_READ = 1 with MEM_ADDRESS = 0x0000000.
  - UPDATE after MEM_BUSYWAIT falls.
  - Next cycle: READ_DATA = 0x11, BUSYWAIT = 0.
- Same-block hits: after the fill, ADDRESS = 0x4, 0x8, 0xC on successive cycles → READ_DATA = 0x22, 0x33, 0x44 with BUSYWAIT = 0 and no MEM_READ.
- Conflict eviction: fill 0x00000000, then ADDRESS = 0x00000080 (same index 0, tag 1).
  - Result: miss, MEM_ADDRESS = 0x0000008, refill.
  - Returning to 0x00000000 misses again.
- Zero-wait memory: MEM_BUSYWAIT tied 0 → a miss costs exactly 2 stall cycles (MEM_READ, UPDATE), then a hit.
- Reset mid-miss: assert RESET while in MEM_READ.
  - MEM_READ drops immediately (asynchronous).
  - After release, the same ADDRESS misses again (line not valid).
- With I_CACHE_PERF_EN: sequence miss@0x0, hits @0x4/0x8, miss@0x80 → HIT_COUNT = 3 (including the post-fill hit at 0x0), MISS_COUNT = 2.
